// File: rtl/nf_share_arbiter_avlstrm_pkg.sv
// Shared types and constants for the non-fast-pattern share arbiter.
package nf_share_arbiter_avlstrm_pkg;

    // Per-packet metadata word carried alongside each packet.
    typedef struct packed {
        logic [15:0] flow_id;
        logic [7:0]  port;
        logic [7:0]  flags;
    } metadata_t;

    // Packet-atomic arbitration phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        META = 2'd1,
        BODY = 2'd2
    } arb_state_t;

    // Stats-packer register addresses for the exported counters.
    localparam logic [7:0] REG_NF_ARB_PKT   = 8'h40;
    localparam logic [7:0] REG_NF_ARB_STALL = 8'h44;
    localparam logic [7:0] REG_NF_ARB_ERR   = 8'h48;

    // Saturating 32-bit add, used by the error counter.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input int n);
        logic [32:0] s;
        s = {1'b0, a} + 33'(n);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/nf_share_arbiter_avlstrm_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module nf_share_arbiter_avlstrm_rr_pick #(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [2:0]        ptr,
    output logic [NUM_IN-1:0] onehot,
    output logic [2:0]        idx,
    output logic              any
);

    int j;

    // Walk candidates in priority order starting at ptr; keep the first hit.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            j = (int'(ptr) + k) % NUM_IN;
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = 3'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf_share_arbiter_avlstrm.sv
// Packet-atomic round-robin share arbiter: metadata first, then every beat to EOP.
module nf_share_arbiter_avlstrm
    import nf_share_arbiter_avlstrm_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DW     = 512,
    parameter int EW     = 6,
    parameter int MW     = $bits(metadata_t)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IN*DW-1:0] in_pkt_data,
    input  logic [NUM_IN-1:0]    in_pkt_valid,
    input  logic [NUM_IN-1:0]    in_pkt_sop,
    input  logic [NUM_IN-1:0]    in_pkt_eop,
    input  logic [NUM_IN*EW-1:0] in_pkt_empty,
    output logic [NUM_IN-1:0]    in_pkt_ready,
    input  logic [NUM_IN*MW-1:0] in_meta_data,
    input  logic [NUM_IN-1:0]    in_meta_valid,
    output logic [NUM_IN-1:0]    in_meta_ready,
    output logic [DW-1:0]        out_pkt_data,
    output logic                 out_pkt_valid,
    output logic                 out_pkt_sop,
    output logic                 out_pkt_eop,
    output logic [EW-1:0]        out_pkt_empty,
    input  logic                 out_pkt_ready,
    output logic [MW-1:0]        out_meta_data,
    output logic                 out_meta_valid,
    input  logic                 out_meta_ready,
    output logic [31:0]          stats_pkt,
    output logic [31:0]          stats_stall,
    output logic [31:0]          stats_nosop_err,
    output logic [2:0]           grant_idx
);

    arb_state_t          state, state_nxt;
    logic [2:0]          grant_nxt, rr_ptr, rr_ptr_nxt;
    logic [NUM_IN-1:0]   grant_oh, grant_oh_nxt;
    logic [NUM_IN-1:0]   eligible, pick_oh, drop;
    logic [2:0]          pick_idx;
    logic                pick_any;
    logic                sel_pkt_valid, sel_meta_valid, pkt_done;

    assign eligible = in_meta_valid & in_pkt_valid & in_pkt_sop;

    nf_share_arbiter_avlstrm_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
        .req    (eligible),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Owner-selected data path; a pure mux of held inputs keeps data stable under stall.
    always_comb begin
        out_pkt_data  = '0;
        out_pkt_sop   = 1'b0;
        out_pkt_eop   = 1'b0;
        out_pkt_empty = '0;
        out_meta_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_oh[i]) begin
                out_pkt_data  = in_pkt_data[i*DW +: DW];
                out_pkt_sop   = in_pkt_sop[i];
                out_pkt_eop   = in_pkt_eop[i];
                out_pkt_empty = in_pkt_empty[i*EW +: EW];
                out_meta_data = in_meta_data[i*MW +: MW];
            end
        end
    end

    assign sel_pkt_valid  = |(in_pkt_valid & grant_oh);
    assign sel_meta_valid = |(in_meta_valid & grant_oh);

    // Next-state, handshake steering and head-beat drop decisions.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_idx;
        grant_oh_nxt   = grant_oh;
        rr_ptr_nxt     = rr_ptr;
        in_pkt_ready   = '0;
        in_meta_ready  = '0;
        out_pkt_valid  = 1'b0;
        out_meta_valid = 1'b0;
        drop           = '0;
        case (state)
            IDLE: begin
                // Non-SOP beats at the head can never start a packet; flush them.
                drop         = in_pkt_valid & ~in_pkt_sop;
                in_pkt_ready = rst ? '0 : drop;
                if (pick_any) begin
                    grant_nxt    = pick_idx;
                    grant_oh_nxt = pick_oh;
                    state_nxt    = META;
                end
            end
            META: begin
                out_meta_valid = sel_meta_valid;
                in_meta_ready  = grant_oh & {NUM_IN{out_meta_ready}};
                if (sel_meta_valid && out_meta_ready) state_nxt = BODY;
            end
            BODY: begin
                out_pkt_valid = sel_pkt_valid;
                in_pkt_ready  = grant_oh & {NUM_IN{out_pkt_ready}};
                if (sel_pkt_valid && out_pkt_ready && out_pkt_eop) begin
                    rr_ptr_nxt = (grant_idx == 3'(NUM_IN-1)) ? 3'd0 : grant_idx + 3'd1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM, owner and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            grant_oh  <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_nxt;
            grant_oh  <= grant_oh_nxt;
            rr_ptr    <= rr_ptr_nxt;
        end
    end

    assign pkt_done = out_pkt_valid & out_pkt_ready & out_pkt_eop;

    // Statistics: completed packets and stalls wrap, dropped head beats saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stats_pkt       <= '0;
            stats_stall     <= '0;
            stats_nosop_err <= '0;
        end else begin
            if (pkt_done) stats_pkt <= stats_pkt + 32'd1;
            if (state == BODY && out_pkt_valid && !out_pkt_ready)
                stats_stall <= stats_stall + 32'd1;
            if (|drop) stats_nosop_err <= sat_add32(stats_nosop_err, $countones(drop));
        end
    end

endmodule
